// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch stage (32-bit
// instructions) and the memory stage (64-bit loads/stores), one transaction at a time.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int TYPE_W     = 3,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [TYPE_W-1:0] d_type,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [TYPE_W-1:0] mem_type,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RSP = 2'd2} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_owner_f;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [TYPE_W-1:0]   r_type;
  logic                r_sel_hi;
  logic [SW-1:0]       r_starve;
  logic                r_kill;
  logic                r_if_rvalid;
  logic                r_d_rvalid;
  logic [DATA_W-1:0]   r_rdata;

  logic w_fetch_ok;
  logic w_starve_full;
  logic w_win_d;
  logic w_win_f;
  logic w_rsp;

  // Reset gates the grants so every output reads 0 while reset is held.
  assign w_fetch_ok    = if_req & ~flush;
  assign w_starve_full = (r_starve == SW'(STARVE_MAX));
  assign w_win_d = (r_state == S_IDLE) & reset & d_req & ~(w_fetch_ok & w_starve_full);
  assign w_win_f = (r_state == S_IDLE) & reset & w_fetch_ok & ~w_win_d;
  assign w_rsp   = (r_state == S_RSP) & mem_rvalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_win_d | w_win_f) w_next = S_REQ;
      S_REQ:   if (mem_gnt) w_next = S_RSP;
      S_RSP:   if (mem_rvalid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    if_gnt    = w_win_f;
    d_gnt     = w_win_d;
    mem_req   = (r_state == S_REQ);
    busy      = (r_state != S_IDLE);
    dbg_state = r_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner_f   <= 1'b0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_type      <= '0;
      r_sel_hi    <= 1'b0;
      r_starve    <= '0;
      r_kill      <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_rdata     <= '0;
    end else begin
      if (w_win_d) begin
        r_owner_f <= 1'b0;
        r_addr    <= d_addr;
        r_we      <= d_we;
        r_wdata   <= d_wdata;
        r_type    <= d_type;
        r_sel_hi  <= 1'b0;
      end
      if (w_win_f) begin
        r_owner_f <= 1'b1;
        r_addr    <= if_addr;
        r_we      <= 1'b0;
        r_wdata   <= '0;
        r_type    <= TYPE_W'(3'b110);
        r_sel_hi  <= if_addr[2];
      end
      // Count only losses where fetch was a real contender.
      if (w_win_f)                    r_starve <= '0;
      else if (w_win_d && w_fetch_ok) r_starve <= r_starve + SW'(1);
      if (w_rsp)                                           r_kill <= 1'b0;
      else if ((r_state != S_IDLE) && r_owner_f && flush)  r_kill <= 1'b1;
      r_if_rvalid <= w_rsp & r_owner_f & ~r_kill & ~flush;
      r_d_rvalid  <= w_rsp & ~r_owner_f;
      if (w_rsp) begin
        if (!r_owner_f) r_rdata <= r_we ? '0 : mem_rdata;
        else            r_rdata <= {32'd0, (r_sel_hi ? mem_rdata[63:32] : mem_rdata[31:0])};
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_type  = r_type;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_rdata[31:0];
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_rdata;

endmodule
